emu_video_timing_gen: RTL and testbench
=======================================

// Module: emu_video_timing_gen
// PURPOSE
//  Parametrised raster timing generator for arcade emu cores. Derives pixel-clock enable from the master clock.
//  Produces H/V counters, blanking and sync, with selectable refresh mode (original / NTSC-friendly / custom H+V trim),
//  V-sync position trim and a mode-change toggle for the video scaler. Sits between the OSD status bits and the video pipeline.
// PARAMETERS
//  MCLK_DIV     10   master clocks per pixel (60 MHz -> 6 MHz); >=2
//  H_ACTIVE     256  visible pixels per line
//  H_TOTAL      384  pixels per line, original mode
//  HS_START     296  first hcnt of HSYNC low
//  HS_LEN       32   HSYNC low width, pixels
//  V_ACTIVE     224  visible lines
//  V_TOTAL      264  lines per frame, original mode
//  V_TOTAL_NTSC 262  lines per frame, NTSC-friendly mode (H_TOTAL unchanged)
//  VS_START     240  first vcnt of VSYNC low at zero trim
//  VS_LEN       3    VSYNC low width, lines
//  H_ADJ_STEP   2    pixels added per i_PXCNTR_ADJ_H step
//  V_ADJ_STEP   1    lines added per i_PXCNTR_ADJ_V step
// PORTS
//  i_EMU_MCLK         in   1  master clock
//  i_EMU_INITRST      in   1  async reset, active high
//  i_PXCNTR_ADJ_MODE  in   2  0 original, 1 NTSC-friendly, 2 custom, 3 = original
//  i_PXCNTR_ADJ_H     in   2  custom mode H total trim, 0..3 steps
//  i_PXCNTR_ADJ_V     in   3  custom mode V total trim, 0..7 steps
//  i_VPOS_ADJ         in   4  0 = no offset; 1..15 = VSYNC offset -7..+7 lines
//  o_PXCEN            out  1  one-cycle pixel enable
//  o_HCNT             out  9  horizontal counter
//  o_VCNT             out  9  vertical counter
//  o_HBLANK_n         out  1  low during H blank
//  o_VBLANK_n         out  1  low during V blank
//  o_HSYNC_n          out  1  active-low H sync
//  o_VSYNC_n          out  1  active-low V sync
//  o_FRAME_START      out  1  one-cycle pulse with o_PXCEN at hcnt=0, vcnt=0
//  o_VMODE_TOGGLE     out  1  inverts once per applied timing change
// BEHAVIOUR
//  - Reset: prescaler, counters 0; o_PXCEN 0; blank_n 0; sync_n 1; o_FRAME_START 0; o_VMODE_TOGGLE 0.
//  - Reset loads the shadow config from inputs; no toggle is issued on reset.
//  - Prescaler counts 0..MCLK_DIV-1; o_PXCEN high for exactly the cycle where prescaler = MCLK_DIV-1.
//  - Counters, blank, sync and o_FRAME_START are registered and advance only in the o_PXCEN cycle.
//    They update on the same edge, with zero relative skew. o_FRAME_START is high in the cycle counters hold 0,0.
//  - hcnt 0..htot-1, then wraps to 0 and increments vcnt; vcnt 0..vtot-1, then wraps to 0.
//  - htot/vtot by shadow mode:
//      mode 0/3: H_TOTAL / V_TOTAL
//      mode 1:   H_TOTAL / V_TOTAL_NTSC
//      mode 2:   H_TOTAL + H_ADJ_STEP*adj_h / V_TOTAL + V_ADJ_STEP*adj_v
//  - All arithmetic is 10-bit unsigned; elaboration error if any htot/vtot exceeds 511.
//  - HBLANK_n = (hcnt < H_ACTIVE). VBLANK_n = (vcnt < V_ACTIVE).
//  - HSYNC_n low when HS_START <= hcnt < HS_START+HS_LEN.
//  - VSYNC_n: voff = (i_VPOS_ADJ==0) ? 0 : i_VPOS_ADJ-8. vs0 = (VS_START+voff) mod vtot.
//    VSYNC_n is low for VS_LEN lines from vs0, wrapping modulo vtot.
//  - Shadow config: {mode, adj_h, adj_v, voff} is sampled only on the frame wrap, when hcnt=htot-1 and vcnt=vtot-1 with o_PXCEN.
//    The new totals take effect from the line/frame that starts at 0,0.
//    Mid-frame input changes never alter the current frame.
//  - o_VMODE_TOGGLE inverts on a frame wrap iff the sampled {mode, adj_h, adj_v} differs from the previous shadow.
//    Multiple changes within one frame produce one toggle. A voff-only change never toggles.
//  - Mode 3 is treated exactly as mode 0. Switching 0 <-> 3 is not counted as a change.
//  - If a shrunk htot/vtot is reached while the counter is already beyond it, the counter wraps at its next increment.
//    This cannot occur with frame-boundary sampling and is asserted in simulation.
//  - Async reset mid-frame: all state returns to reset values immediately; restarts at 0,0 after release.
// TESTING
//  - Reset, defaults, mode 0 -> o_PXCEN every 10 clocks; 384*264 pixel enables between o_FRAME_START pulses;
//    HSYNC_n low hcnt 296..327.
//  - Set mode 1 at vcnt=100 -> current frame still 264 lines, next 262; o_VMODE_TOGGLE flips once at wrap.
//  - Mode 2, adj_h=3, adj_v=7 -> 390 pixels/line, 271 lines/frame; one toggle.
//  - i_VPOS_ADJ=1 (-7) -> VSYNC_n low vcnt 233..235. i_VPOS_ADJ=15 (+7) -> vcnt 247..249. No toggle in either case.
//  - Mode 2, adj_v=0 (vtot 264), VS_START override 262 -> VSYNC_n low vcnt 262, 263, 0 (wrap).
//  - Three mode writes within one frame, then mode 0 -> 3 -> single/no toggle as specified.
//    Reset asserted at vcnt=150 -> outputs at reset values immediately.

Source files
------------

// File: rtl/emu_video_timing_gen.sv
// Raster timing generator for arcade emulation cores.
// Derives the pixel enable from the master clock and produces counters, blanking and sync.
// Refresh mode and trims are shadowed at the frame boundary.
module emu_video_timing_gen #(
    parameter int unsigned MCLK_DIV     = 10,
    parameter int unsigned H_ACTIVE     = 256,
    parameter int unsigned H_TOTAL      = 384,
    parameter int unsigned HS_START     = 296,
    parameter int unsigned HS_LEN       = 32,
    parameter int unsigned V_ACTIVE     = 224,
    parameter int unsigned V_TOTAL      = 264,
    parameter int unsigned V_TOTAL_NTSC = 262,
    parameter int unsigned VS_START     = 240,
    parameter int unsigned VS_LEN       = 3,
    parameter int unsigned H_ADJ_STEP   = 2,
    parameter int unsigned V_ADJ_STEP   = 1
) (
    input  logic       i_EMU_MCLK,
    input  logic       i_EMU_INITRST,
    input  logic [1:0] i_PXCNTR_ADJ_MODE,
    input  logic [1:0] i_PXCNTR_ADJ_H,
    input  logic [2:0] i_PXCNTR_ADJ_V,
    input  logic [3:0] i_VPOS_ADJ,
    output logic       o_PXCEN,
    output logic [8:0] o_HCNT,
    output logic [8:0] o_VCNT,
    output logic       o_HBLANK_n,
    output logic       o_VBLANK_n,
    output logic       o_HSYNC_n,
    output logic       o_VSYNC_n,
    output logic       o_FRAME_START,
    output logic       o_VMODE_TOGGLE
);

    localparam int unsigned PW     = $clog2(MCLK_DIV);
    localparam int unsigned CW     = 10;
    localparam int unsigned H_MAX  = H_TOTAL + 3 * H_ADJ_STEP;
    localparam int unsigned V_MAXC = V_TOTAL + 7 * V_ADJ_STEP;

    localparam logic [1:0] MODE_ORIG   = 2'd0;
    localparam logic [1:0] MODE_NTSC   = 2'd1;
    localparam logic [1:0] MODE_CUSTOM = 2'd2;

    // Reject configurations that cannot be represented in the 9-bit counters
    if (MCLK_DIV < 2) begin : g_div_err
        $error("MCLK_DIV must be at least 2");
    end
    if (H_MAX > 511 || V_MAXC > 511 || V_TOTAL_NTSC > 511 || V_TOTAL > 511) begin : g_tot_err
        $error("line or frame total exceeds 511");
    end

    // Line length for a given shadow mode
    function automatic logic [CW-1:0] calc_htot(input logic [1:0] mode, input logic [1:0] adj_h);
        calc_htot = CW'(H_TOTAL);
        if (mode == MODE_CUSTOM) calc_htot = CW'(H_TOTAL) + CW'(H_ADJ_STEP) * CW'(adj_h);
    endfunction

    // Frame length for a given shadow mode
    function automatic logic [CW-1:0] calc_vtot(input logic [1:0] mode, input logic [2:0] adj_v);
        calc_vtot = CW'(V_TOTAL);
        if (mode == MODE_NTSC)   calc_vtot = CW'(V_TOTAL_NTSC);
        if (mode == MODE_CUSTOM) calc_vtot = CW'(V_TOTAL) + CW'(V_ADJ_STEP) * CW'(adj_v);
    endfunction

    // First VSYNC line: VS_START plus signed offset (vpos-8), folded into 0..vtot-1
    function automatic logic [CW-1:0] calc_vs0(input logic [CW-1:0] vtot, input logic [3:0] vpos);
        logic [CW-1:0] a;
        logic [CW-1:0] s;
        a = (vpos == 4'd0) ? CW'(8) : CW'(vpos);
        s = CW'(VS_START) + a;
        if (s < CW'(8))                calc_vs0 = s + vtot - CW'(8);
        else if (s - CW'(8) >= vtot)   calc_vs0 = s - CW'(8) - vtot;
        else                           calc_vs0 = s - CW'(8);
    endfunction

    // VSYNC window test with wrap modulo vtot
    function automatic logic vs_low(input logic [CW-1:0] v, input logic [CW-1:0] vtot,
                                    input logic [CW-1:0] vs0);
        logic [CW-1:0] d;
        d = (v >= vs0) ? (v - vs0) : (v + vtot - vs0);
        vs_low = (d < CW'(VS_LEN));
    endfunction

    logic [PW-1:0] presc, presc_nx;
    logic          pxcen_q, pxcen_nx;
    logic [8:0]    hcnt, hcnt_nx, vcnt, vcnt_nx;
    logic          hblank_n_q, hblank_n_nx, vblank_n_q, vblank_n_nx;
    logic          hsync_n_q, hsync_n_nx, vsync_n_q, vsync_n_nx;
    logic          fstart_q, fstart_nx, toggle_q, toggle_nx;
    logic          cfg_valid;
    logic [1:0]    sh_mode, sh_mode_nx, sh_adj_h, sh_adj_h_nx;
    logic [2:0]    sh_adj_v, sh_adj_v_nx;
    logic [3:0]    sh_vpos, sh_vpos_nx;
    logic [1:0]    in_mode;
    logic [CW-1:0] htot, vtot, vtot_nx, h_ext, v_ext;
    logic          h_end, v_end, frame_wrap, cfg_chg;

    // Next-state logic: prescaler, counters, shadow config and registered video outputs
    always_comb begin
        presc_nx    = pxcen_q ? '0 : presc + PW'(1);
        pxcen_nx    = (presc == PW'(MCLK_DIV - 2));
        fstart_nx   = pxcen_nx && (hcnt == 9'd0) && (vcnt == 9'd0);
        hcnt_nx     = hcnt;
        vcnt_nx     = vcnt;
        hblank_n_nx = hblank_n_q;
        vblank_n_nx = vblank_n_q;
        hsync_n_nx  = hsync_n_q;
        vsync_n_nx  = vsync_n_q;
        toggle_nx   = toggle_q;
        sh_mode_nx  = sh_mode;
        sh_adj_h_nx = sh_adj_h;
        sh_adj_v_nx = sh_adj_v;
        sh_vpos_nx  = sh_vpos;

        in_mode    = (i_PXCNTR_ADJ_MODE == 2'd3) ? MODE_ORIG : i_PXCNTR_ADJ_MODE;
        htot       = calc_htot(sh_mode, sh_adj_h);
        vtot       = calc_vtot(sh_mode, sh_adj_v);
        h_end      = ({1'b0, hcnt} >= htot - CW'(1));
        v_end      = ({1'b0, vcnt} >= vtot - CW'(1));
        frame_wrap = pxcen_q && h_end && v_end;
        cfg_chg    = {in_mode, i_PXCNTR_ADJ_H, i_PXCNTR_ADJ_V} != {sh_mode, sh_adj_h, sh_adj_v};

        if (!cfg_valid || frame_wrap) begin
            sh_mode_nx  = in_mode;
            sh_adj_h_nx = i_PXCNTR_ADJ_H;
            sh_adj_v_nx = i_PXCNTR_ADJ_V;
            sh_vpos_nx  = i_VPOS_ADJ;
        end
        if (frame_wrap && cfg_chg) toggle_nx = ~toggle_q;

        if (pxcen_q) begin
            if (h_end) begin
                hcnt_nx = 9'd0;
                vcnt_nx = v_end ? 9'd0 : vcnt + 9'd1;
            end else begin
                hcnt_nx = hcnt + 9'd1;
            end
        end

        h_ext   = {1'b0, hcnt_nx};
        v_ext   = {1'b0, vcnt_nx};
        vtot_nx = calc_vtot(sh_mode_nx, sh_adj_v_nx);
        if (pxcen_q) begin
            hblank_n_nx = (h_ext < CW'(H_ACTIVE));
            vblank_n_nx = (v_ext < CW'(V_ACTIVE));
            hsync_n_nx  = !((h_ext >= CW'(HS_START)) && (h_ext < CW'(HS_START + HS_LEN)));
            vsync_n_nx  = !vs_low(v_ext, vtot_nx, calc_vs0(vtot_nx, sh_vpos_nx));
        end
    end

    // State registers
    always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
        if (i_EMU_INITRST) begin
            presc      <= '0;
            pxcen_q    <= 1'b0;
            hcnt       <= 9'd0;
            vcnt       <= 9'd0;
            hblank_n_q <= 1'b0;
            vblank_n_q <= 1'b0;
            hsync_n_q  <= 1'b1;
            vsync_n_q  <= 1'b1;
            fstart_q   <= 1'b0;
            toggle_q   <= 1'b0;
            cfg_valid  <= 1'b0;
            sh_mode    <= 2'd0;
            sh_adj_h   <= 2'd0;
            sh_adj_v   <= 3'd0;
            sh_vpos    <= 4'd0;
        end else begin
            presc      <= presc_nx;
            pxcen_q    <= pxcen_nx;
            hcnt       <= hcnt_nx;
            vcnt       <= vcnt_nx;
            hblank_n_q <= hblank_n_nx;
            vblank_n_q <= vblank_n_nx;
            hsync_n_q  <= hsync_n_nx;
            vsync_n_q  <= vsync_n_nx;
            fstart_q   <= fstart_nx;
            toggle_q   <= toggle_nx;
            cfg_valid  <= 1'b1;
            sh_mode    <= sh_mode_nx;
            sh_adj_h   <= sh_adj_h_nx;
            sh_adj_v   <= sh_adj_v_nx;
            sh_vpos    <= sh_vpos_nx;
        end
    end

    // Counters never sit beyond the active totals
    a_cnt_in_range: assert property (@(posedge i_EMU_MCLK) disable iff (i_EMU_INITRST)
        (({1'b0, hcnt} < htot) && ({1'b0, vcnt} < vtot)));

    assign o_PXCEN        = pxcen_q;
    assign o_HCNT         = hcnt;
    assign o_VCNT         = vcnt;
    assign o_HBLANK_n     = hblank_n_q;
    assign o_VBLANK_n     = vblank_n_q;
    assign o_HSYNC_n      = hsync_n_q;
    assign o_VSYNC_n      = vsync_n_q;
    assign o_FRAME_START  = fstart_q;
    assign o_VMODE_TOGGLE = toggle_q;

endmodule

// File: tb/tb_emu_video_timing_gen.sv
// Directed bench: full-size instance for pixel/line timing, scaled instances for frame-level behaviour.
module tb_emu_video_timing_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [1:0] adj_h;
    logic [2:0] adj_v;
    logic [3:0] vpos;

    logic       a_pxcen, a_hbl, a_vbl, a_hs, a_vs, a_fs, a_tgl;
    logic [8:0] a_hcnt, a_vcnt;
    logic       b_pxcen, b_hbl, b_vbl, b_hs, b_vs, b_fs, b_tgl;
    logic [8:0] b_hcnt, b_vcnt;
    logic       c_pxcen, c_hbl, c_vbl, c_hs, c_vs, c_fs, c_tgl;
    logic [8:0] c_hcnt, c_vcnt;

    always #5 clk = ~clk;

    emu_video_timing_gen u_full (
        .i_EMU_MCLK(clk), .i_EMU_INITRST(rst), .i_PXCNTR_ADJ_MODE(mode),
        .i_PXCNTR_ADJ_H(adj_h), .i_PXCNTR_ADJ_V(adj_v), .i_VPOS_ADJ(vpos),
        .o_PXCEN(a_pxcen), .o_HCNT(a_hcnt), .o_VCNT(a_vcnt), .o_HBLANK_n(a_hbl),
        .o_VBLANK_n(a_vbl), .o_HSYNC_n(a_hs), .o_VSYNC_n(a_vs),
        .o_FRAME_START(a_fs), .o_VMODE_TOGGLE(a_tgl));

    emu_video_timing_gen #(
        .MCLK_DIV(2), .H_ACTIVE(16), .H_TOTAL(24), .HS_START(18), .HS_LEN(3),
        .V_ACTIVE(16), .V_TOTAL(28), .V_TOTAL_NTSC(26), .VS_START(18), .VS_LEN(3),
        .H_ADJ_STEP(2), .V_ADJ_STEP(1)
    ) u_small (
        .i_EMU_MCLK(clk), .i_EMU_INITRST(rst), .i_PXCNTR_ADJ_MODE(mode),
        .i_PXCNTR_ADJ_H(adj_h), .i_PXCNTR_ADJ_V(adj_v), .i_VPOS_ADJ(vpos),
        .o_PXCEN(b_pxcen), .o_HCNT(b_hcnt), .o_VCNT(b_vcnt), .o_HBLANK_n(b_hbl),
        .o_VBLANK_n(b_vbl), .o_HSYNC_n(b_hs), .o_VSYNC_n(b_vs),
        .o_FRAME_START(b_fs), .o_VMODE_TOGGLE(b_tgl));

    emu_video_timing_gen #(
        .MCLK_DIV(2), .H_ACTIVE(16), .H_TOTAL(24), .HS_START(18), .HS_LEN(3),
        .V_ACTIVE(16), .V_TOTAL(28), .V_TOTAL_NTSC(26), .VS_START(26), .VS_LEN(3),
        .H_ADJ_STEP(2), .V_ADJ_STEP(1)
    ) u_vswrap (
        .i_EMU_MCLK(clk), .i_EMU_INITRST(rst), .i_PXCNTR_ADJ_MODE(mode),
        .i_PXCNTR_ADJ_H(adj_h), .i_PXCNTR_ADJ_V(adj_v), .i_VPOS_ADJ(vpos),
        .o_PXCEN(c_pxcen), .o_HCNT(c_hcnt), .o_VCNT(c_vcnt), .o_HBLANK_n(c_hbl),
        .o_VBLANK_n(c_vbl), .o_HSYNC_n(c_hs), .o_VSYNC_n(c_vs),
        .o_FRAME_START(c_fs), .o_VMODE_TOGGLE(c_tgl));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Per-frame statistics of the scaled instance, latched at each frame start
    int frame_idx = 0;
    int flips = 0;
    bit started = 1'b0;
    logic tgl_prev = 1'b0;
    int acc_pix, acc_hmax, acc_vmax, acc_vs_first, acc_vs_cnt;
    int last_pix, last_hlen, last_lines, last_vs_first, last_vs_cnt;
    int c_vs_q[$];
    int c_last_q[$];

    always @(negedge clk) begin
        if (rst) begin
            started  = 1'b0;
            tgl_prev = b_tgl;
        end else begin
            if (b_tgl !== tgl_prev) flips++;
            tgl_prev = b_tgl;
            if (b_pxcen) begin
                if (b_fs) begin
                    if (started) begin
                        last_pix      = acc_pix;
                        last_hlen     = acc_hmax + 1;
                        last_lines    = acc_vmax + 1;
                        last_vs_first = acc_vs_first;
                        last_vs_cnt   = acc_vs_cnt;
                        c_last_q      = c_vs_q;
                        frame_idx++;
                    end
                    started      = 1'b1;
                    acc_pix      = 0;
                    acc_hmax     = 0;
                    acc_vmax     = 0;
                    acc_vs_first = -1;
                    acc_vs_cnt   = 0;
                    c_vs_q.delete();
                end
                acc_pix++;
                if (int'(b_hcnt) > acc_hmax) acc_hmax = int'(b_hcnt);
                if (int'(b_vcnt) > acc_vmax) acc_vmax = int'(b_vcnt);
                if (b_hcnt == 9'd0 && !b_vs) begin
                    if (acc_vs_first < 0) acc_vs_first = int'(b_vcnt);
                    acc_vs_cnt++;
                end
                if (c_hcnt == 9'd0 && !c_vs) c_vs_q.push_back(int'(c_vcnt));
            end
        end
    end

    task automatic wait_frames(input int n);
        int target;
        int t;
        target = frame_idx + n;
        t = 0;
        while (frame_idx < target && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (frame_idx < target) check("frame_timeout", frame_idx, target);
    endtask

    task automatic wait_line(input int v);
        int t;
        t = 0;
        while (int'(b_vcnt) != v && t < 8000) begin
            @(negedge clk);
            t++;
        end
        if (int'(b_vcnt) != v) check("line_timeout", int'(b_vcnt), v);
    endtask

    task automatic check_reset_outputs(input string who, input logic pxcen, input logic [8:0] h,
                                       input logic [8:0] v, input logic hbl, input logic vbl,
                                       input logic hs, input logic vs, input logic fs, input logic tg);
        check({who, "_pxcen"}, int'(pxcen), 0);
        check({who, "_hcnt"},  int'(h), 0);
        check({who, "_vcnt"},  int'(v), 0);
        check({who, "_hblank_n"}, int'(hbl), 0);
        check({who, "_vblank_n"}, int'(vbl), 0);
        check({who, "_hsync_n"},  int'(hs), 1);
        check({who, "_vsync_n"},  int'(vs), 1);
        check({who, "_frame_start"}, int'(fs), 0);
        check({who, "_toggle"}, int'(tg), 0);
    endtask

    initial begin
        int f, t, period, hs_first, hs_last, hb_first;
        int q0, q1, q2;
        rst = 1'b1; mode = 2'd0; adj_h = 2'd0; adj_v = 3'd0; vpos = 4'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst", a_pxcen, a_hcnt, a_vcnt, a_hbl, a_vbl, a_hs, a_vs, a_fs, a_tgl);
        rst = 1'b0;

        // Pixel enable period on the full-size instance
        for (int k = 0; k < 2; k++) begin
            t = 0;
            while (!a_pxcen && t < 50) begin @(negedge clk); t++; end
            period = 0;
            do begin @(negedge clk); period++; end while (!a_pxcen && period < 50);
            check("pxcen_period", period, 10);
        end

        // HSYNC and HBLANK across the first line
        hs_first = -1; hs_last = -1; hb_first = -1; t = 0;
        while (int'(a_hcnt) < 340 && t < 5000) begin
            @(negedge clk); t++;
            if (a_pxcen) begin
                if (!a_hs) begin
                    if (hs_first < 0) hs_first = int'(a_hcnt);
                    hs_last = int'(a_hcnt);
                end
                if (a_hcnt != 9'd0 && !a_hbl && hb_first < 0) hb_first = int'(a_hcnt);
            end
        end
        check("hsync_first", hs_first, 296);
        check("hsync_last", hs_last, 327);
        check("hblank_first", hb_first, 256);

        // Original mode frame
        wait_frames(1);
        check("m0_pix", last_pix, 672);
        check("m0_hlen", last_hlen, 24);
        check("m0_lines", last_lines, 28);
        check("m0_vs_first", last_vs_first, 18);
        check("m0_vs_cnt", last_vs_cnt, 3);

        // NTSC-friendly requested mid-frame
        f = flips;
        wait_line(10); mode = 2'd1;
        wait_frames(1);
        check("ntsc_cur_lines", last_lines, 28);
        check("ntsc_toggle_at_wrap", flips - f, 1);
        wait_frames(1);
        check("ntsc_lines", last_lines, 26);
        check("ntsc_pix", last_pix, 624);
        check("ntsc_toggle_once", flips - f, 1);

        // Custom trim
        f = flips;
        wait_line(5); mode = 2'd2; adj_h = 2'd3; adj_v = 3'd7;
        wait_frames(1);
        check("cust_cur_lines", last_lines, 26);
        wait_frames(1);
        check("cust_hlen", last_hlen, 30);
        check("cust_lines", last_lines, 35);
        check("cust_pix", last_pix, 1050);
        check("cust_toggle", flips - f, 1);

        // VSYNC position trim, never toggles
        f = flips;
        wait_line(5); vpos = 4'd1;
        wait_frames(2);
        check("vpos_m7_first", last_vs_first, 11);
        check("vpos_m7_cnt", last_vs_cnt, 3);
        wait_line(5); vpos = 4'd15;
        wait_frames(2);
        check("vpos_p7_first", last_vs_first, 25);
        check("vpos_p7_cnt", last_vs_cnt, 3);
        check("vpos_lines", last_lines, 35);
        check("vpos_no_toggle", flips - f, 0);

        // Three writes in one frame ending on the current config
        f = flips;
        wait_line(3); mode = 2'd1;
        wait_line(6); mode = 2'd0; adj_h = 2'd0; adj_v = 3'd0;
        wait_line(9); mode = 2'd2; adj_h = 2'd3; adj_v = 3'd7;
        wait_frames(2);
        check("multi_same_toggle", flips - f, 0);
        check("multi_same_lines", last_lines, 35);

        // Three writes in one frame ending on a new config
        f = flips;
        wait_line(3); mode = 2'd1;
        wait_line(6); mode = 2'd2;
        wait_line(9); mode = 2'd0; adj_h = 2'd0; adj_v = 3'd0;
        wait_frames(2);
        check("multi_chg_toggle", flips - f, 1);
        check("multi_chg_lines", last_lines, 28);

        // Mode 3 aliases mode 0
        f = flips;
        wait_line(4); mode = 2'd3;
        wait_frames(2);
        check("m3_toggle", flips - f, 0);
        check("m3_lines", last_lines, 28);
        check("m3_hlen", last_hlen, 24);

        // VSYNC window wrapping through vcnt 0 on the late-VSYNC instance
        wait_line(4); mode = 2'd2; adj_h = 2'd0; adj_v = 3'd0; vpos = 4'd0;
        wait_frames(2);
        check("wrap_lines", last_lines, 28);
        check("wrap_vs_cnt", c_last_q.size(), 3);
        q0 = (c_last_q.size() > 0) ? c_last_q[0] : -1;
        q1 = (c_last_q.size() > 1) ? c_last_q[1] : -1;
        q2 = (c_last_q.size() > 2) ? c_last_q[2] : -1;
        check("wrap_vs_0", q0, 0);
        check("wrap_vs_1", q1, 26);
        check("wrap_vs_2", q2, 27);
        check("wrap_b_vs_first", last_vs_first, 18);

        // Asynchronous reset mid-frame
        wait_line(15);
        check("pre_rst_vcnt", int'(b_vcnt), 15);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst", b_pxcen, b_hcnt, b_vcnt, b_hbl, b_vbl, b_hs, b_vs, b_fs, b_tgl);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_frames(1);
        check("post_rst_lines", last_lines, 28);
        check("post_rst_hlen", last_hlen, 24);
        check("post_rst_no_toggle", int'(b_tgl), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
